// File: rtl/pin_display.sv
// pin_display -- multiplexed 4-digit 7-segment driver for PIN entry.
//
// Purpose:
//   Scans four BCD digits onto a common-anode style display (active-low
//   segments and digit enables). The displayed value comes from shadow
//   registers that are captured on load_i. While a PIN is being edited,
//   the digit under the cursor blinks with a half-period of BLINK_FRAMES
//   full 4-digit frames.
//
// Optional feature (macro PIN_MASK_EN):
//   When defined, digits left of the cursor while editing, and every digit
//   when not editing, are shown as '-' instead of their value. The cursor
//   digit still shows its value and blinks. When undefined, no masking
//   logic is built.
//
// Parameters:
//   SCAN_DIV      clock cycles each digit is driven (2..2^20)
//   BLINK_FRAMES  full frames per cursor blink half-period (1..255)
//
// Ports:
//   clk_i        in   1   clock, all state changes on rising edge
//   rst_n_i      in   1   synchronous active-low reset (wins over load_i)
//   pin_vec_i    in  16   four BCD digits, digit k at [4k+3:4k], digit 0 leftmost
//   digit_idx_i  in   2   cursor digit index
//   edit_i       in   1   PIN entry in progress (enables blink)
//   load_i       in   1   capture strobe for pin_vec_i / digit_idx_i / edit_i
//   seg_o        out  7   active-low segments, [0]=a .. [6]=g (registered)
//   an_o         out  4   active-low digit enables, an_o[k] = digit k (registered)
//   frame_o      out  1   one-cycle pulse when a full 4-digit scan completes
//
// Handshake: load_i is a plain strobe with no back-pressure; every cycle with
// load_i=1 and rst_n_i=1 overwrites the shadow registers.

module pin_display #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] pin_vec_i,
    input  logic [1:0]  digit_idx_i,
    input  logic        edit_i,
    input  logic        load_i,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        frame_o
);

    localparam int         CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [7:0]    BLINK_MAX = 8'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // shadow copy of the inputs; the display reads only these
    logic [15:0]   shadow_pin;
    logic [1:0]    shadow_idx;
    logic          shadow_edit;

    logic [CW-1:0] scan_cnt;
    logic [1:0]    ptr;
    logic [7:0]    frame_cnt;
    logic          blink;

    // low during the first cycle after reset so the outputs stay dark for
    // one extra cycle before the first digit is driven
    logic          run;

    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          frame_q;

    logic          scan_wrap;
    logic          frame_done;
    logic          idx_change;
    logic [3:0]    nibble;
    logic [6:0]    seg_next;

    assign scan_wrap  = (scan_cnt == SCAN_MAX);
    assign frame_done = scan_wrap && (ptr == 2'd3);
    assign idx_change = load_i && (digit_idx_i != shadow_idx);

    always_comb begin
        nibble   = shadow_pin[3:0];
        seg_next = SEG_BLANK;

        case (ptr)
            2'd0:    nibble = shadow_pin[3:0];
            2'd1:    nibble = shadow_pin[7:4];
            2'd2:    nibble = shadow_pin[11:8];
            default: nibble = shadow_pin[15:12];
        endcase

        case (nibble)
            4'd0:    seg_next = 7'b1000000;
            4'd1:    seg_next = 7'b1111001;
            4'd2:    seg_next = 7'b0100100;
            4'd3:    seg_next = 7'b0110000;
            4'd4:    seg_next = 7'b0011001;
            4'd5:    seg_next = 7'b0010010;
            4'd6:    seg_next = 7'b0000010;
            4'd7:    seg_next = 7'b1111000;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0010000;
            default: seg_next = SEG_BLANK;
        endcase

`ifdef PIN_MASK_EN
        // masking first, so the blink below still acts on the cursor digit
        if (!shadow_edit || (ptr < shadow_idx)) begin
            seg_next = SEG_DASH;
        end
`endif

        if (shadow_edit && (ptr == shadow_idx) && blink) begin
            seg_next = SEG_BLANK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            shadow_pin  <= '0;
            shadow_idx  <= '0;
            shadow_edit <= 1'b0;
            scan_cnt    <= '0;
            ptr         <= '0;
            frame_cnt   <= '0;
            blink       <= 1'b0;
            run         <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= 4'b1111;
            frame_q     <= 1'b0;
        end else begin
            run <= 1'b1;

            // scan timing is free-running; load_i never touches it
            if (scan_wrap) begin
                scan_cnt <= '0;
                ptr      <= ptr + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end

            frame_q <= frame_done;

            // a cursor move restarts the blink in its visible phase; this
            // takes precedence over a frame completing in the same cycle
            if (idx_change) begin
                frame_cnt <= '0;
                blink     <= 1'b0;
            end else if (frame_done) begin
                if (frame_cnt == BLINK_MAX) begin
                    frame_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end

            if (load_i) begin
                shadow_pin  <= pin_vec_i;
                shadow_idx  <= digit_idx_i;
                shadow_edit <= edit_i;
            end

            if (run) begin
                an_q  <= ~(4'b0001 << ptr);
                seg_q <= seg_next;
            end else begin
                an_q  <= 4'b1111;
                seg_q <= SEG_BLANK;
            end
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_pin_display.sv
// tb_pin_display -- self-checking bench for pin_display (SCAN_DIV=4,
// BLINK_FRAMES=2). Expected outputs come from a closed-form reference model
// based on the count of clock edges since reset release. Honours PIN_MASK_EN
// when defined.

module tb_pin_display;

    localparam int SD = 4;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pin = '0;
    logic [1:0]  idx = '0;
    logic        edit = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    pin_display #(
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .pin_vec_i   (pin),
        .digit_idx_i (idx),
        .edit_i      (edit),
        .load_i      (load),
        .seg_o       (seg),
        .an_o        (an),
        .frame_o     (frame)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // reference model state
    int          n    = 0;   // clock edges seen since reset release
    int          base = 0;   // frame count at the last cursor move
    logic [15:0] m_pin  = '0;
    logic [1:0]  m_idx  = '0;
    logic        m_edit = 1'b0;
    logic [6:0]  e_seg  = 7'h7f;
    logic [3:0]  e_an   = 4'hf;
    logic        e_frame = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s at %0t: got %h want %h", phase, tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] digit_pattern(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs applied to it.
    // Before edge number n (n edges already seen since release), the digit
    // on display is (n / SD) % 4, (n / (4*SD)) frames are complete, and the
    // blink phase is the parity of whole BF-frame groups since the last
    // cursor move.
    task automatic model_edge();
        int         p;
        int         f;
        logic       bl;
        logic [6:0] s;
        logic [3:0] one;
        one = 4'b0001;
        if (!rst_n) begin
            n       = 0;
            base    = 0;
            m_pin   = '0;
            m_idx   = '0;
            m_edit  = 1'b0;
            e_an    = 4'b1111;
            e_seg   = 7'b1111111;
            e_frame = 1'b0;
        end else begin
            p  = (n / SD) % 4;
            f  = n / (4 * SD);
            bl = (((f - base) / BF) % 2) == 1;
            s  = digit_pattern(m_pin[p*4 +: 4]);
`ifdef PIN_MASK_EN
            if (!m_edit || (p < int'(m_idx))) s = 7'b0111111;
`endif
            if (m_edit && (p == int'(m_idx)) && bl) s = 7'b1111111;
            if (n >= 1) begin
                e_an  = ~(one << p);
                e_seg = s;
            end else begin
                e_an  = 4'b1111;
                e_seg = 7'b1111111;
            end
            e_frame = ((n + 1) % (4 * SD)) == 0;
            if (load) begin
                if (idx != m_idx) base = (n + 1) / (4 * SD);
                m_pin  = pin;
                m_idx  = idx;
                m_edit = edit;
            end
            n++;
        end
    endtask

    // One clock: apply inputs, step the model on the edge, compare at negedge.
    task automatic cycle(input logic r, input logic l, input logic [15:0] pv,
                         input logic [1:0] di, input logic ed);
        rst_n = r;
        load  = l;
        pin   = pv;
        idx   = di;
        edit  = ed;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("an", 16'(an), 16'(e_an));
        check("seg", 16'(seg), 16'(e_seg));
        check("frame", 16'(frame), 16'(e_frame));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b1, 1'b0, pin, idx, edit);
    endtask

    initial begin
        // reset and plain scan of an all-zero shadow
        phase = "reset_scan";
        cycle(1'b0, 1'b0, 16'h0000, 2'd0, 1'b0);
        cycle(1'b0, 1'b1, 16'h1234, 2'd1, 1'b1);
        idle(40);

        // decode of digits including an out-of-range nibble
        phase = "decode";
        cycle(1'b1, 1'b1, 16'h9A38, 2'd0, 1'b0);
        idle(40);

        // cursor blink on digit 2
        phase = "blink";
        cycle(1'b1, 1'b1, 16'h9A38, 2'd2, 1'b1);
        idle(100);

        // cursor move while digit 2 is in its blank phase
        phase = "cursor_move";
        for (int i = 0; i < 200; i++) begin
            if ((((n / (4 * SD)) - base) / BF) % 2 == 1) break;
            cycle(1'b1, 1'b0, pin, idx, edit);
        end
        cycle(1'b1, 1'b1, 16'h9A38, 2'd3, 1'b1);
        idle(60);

        // masking pattern (plain digits when masking is not built)
        phase = "mask";
        cycle(1'b1, 1'b1, 16'h4321, 2'd2, 1'b1);
        idle(80);
        cycle(1'b1, 1'b1, 16'h4321, 2'd2, 1'b0);
        idle(20);

        // reset together with a load while digit 2 is scanned
        phase = "reset_load";
        for (int i = 0; i < 64; i++) begin
            if ((n / SD) % 4 == 2) break;
            cycle(1'b1, 1'b0, pin, idx, edit);
        end
        check("ptr_reached", 16'((n / SD) % 4), 16'd2);
        cycle(1'b0, 1'b1, 16'h5555, 2'd1, 1'b1);
        idle(30);

        // randomized loads and occasional resets
        phase = "random";
        for (int i = 0; i < 2000; i++) begin
            logic        r;
            logic        l;
            logic [15:0] pv;
            logic [1:0]  di;
            logic        ed;
            r  = ($urandom_range(0, 299) != 0);
            l  = ($urandom_range(0, 24) == 0);
            pv = 16'($urandom);
            di = 2'($urandom_range(0, 3));
            ed = 1'($urandom_range(0, 1));
            cycle(r, l, pv, di, ed);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pin_display.md
PIN_DISPLAY -- requirements
Module: pin_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit is driven; legal range 2..2^20.
REQ-002 SHALL have parameter BLINK_FRAMES, default 64: full 4-digit frames per cursor blink half-period; legal range 1..255.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port pin_vec_i, input, 16: four BCD digits; digit k at [4k+3:4k], digit 0 leftmost.
REQ-006 SHALL have port digit_idx_i, input, 2: index of the digit currently being edited.
REQ-007 SHALL have port edit_i, input, 1: PIN entry in progress, which enables the cursor blink.
REQ-008 SHALL have port load_i, input, 1: capture strobe for pin_vec_i, digit_idx_i and edit_i.
REQ-009 SHALL have port seg_o, output, 7: active-low segments, seg_o[0]=a through seg_o[6]=g.
REQ-010 SHALL have port an_o, output, 4: active-low digit enables, an_o[k] selects digit k.
REQ-011 SHALL have port frame_o, output, 1: one-cycle pulse when a full 4-digit scan completes.

Function
REQ-012 SHALL, on a clock edge with load_i=1, copy pin_vec_i, digit_idx_i and edit_i into shadow registers; the display SHALL use only the shadow registers.
REQ-013 SHALL run scan counter 0..SCAN_DIV-1; on wrap, the digit pointer SHALL advance 0->1->2->3->0.
REQ-014 SHALL pulse frame_o high for one cycle on the cycle the pointer wraps from 3 to 0.
REQ-015 SHALL register seg_o and an_o, so each reflects the pointer and shadow state one cycle after they change.
REQ-016 SHALL drive an_o with exactly one bit low (the pointer digit) in every cycle except reset and the first cycle after reset.
REQ-017 SHALL decode BCD 0-9 to standard 7-segment patterns (0 -> 7'b1000000, 8 -> 7'b0000000).
REQ-018 SHALL blank nibbles 10-15 (seg_o=7'b1111111).
REQ-019 SHALL count completed frames and toggle a blink phase bit after every BLINK_FRAMES frames.
REQ-020 SHALL blank the pointer digit when shadow edit=1, pointer equals shadow idx, and blink phase=1.
REQ-021 SHALL reset the blink phase to 0 and the frame count to 0 on any load_i that changes shadow idx, so a new cursor position is visible immediately.
REQ-022 SHALL leave the scan counter and pointer undisturbed by load_i.
REQ-023 SHALL, when load_i=1 and rst_n_i=0 in the same cycle, give priority to reset.

Reset
REQ-024 SHALL, with rst_n_i=0 at a clock edge, clear the shadow registers, scan counter, pointer, frame count and blink phase to 0.
REQ-025 SHALL hold an_o=4'b1111, seg_o=7'b1111111 and frame_o=0 while in reset.
REQ-026 SHALL drive digit 0 on the second cycle after reset release (an_o=4'b1110, seg_o=7'b1000000).

Configuration
REQ-027 SHALL implement masking when macro PIN_MASK_EN is defined: a digit with index < shadow idx while edit=1, or any digit while edit=0, SHALL be shown as '-' (seg_o=7'b0111111).
REQ-028 SHALL apply PIN_MASK_EN masking before the blink rule of REQ-020, so the cursor digit remains visible and blinking.
REQ-029 SHALL, when PIN_MASK_EN is undefined, display all digits per REQ-017/REQ-018 with no masking logic present.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-030 Reset/scan: release reset with shadow=0 -> an_o cycles 1110,1101,1011,0111 every 4 cycles with seg_o=1000000, and frame_o pulses every 16 cycles.
REQ-031 Decode: load pin_vec_i=16'h9A38 with edit=0 -> digits 0..3 show 8 (0000000), 3 (0110000), blank (1111111), 9 (0010000); masking is off.
REQ-032 Blink: load edit=1, idx=2 -> digit 2 is visible for frames 0-1, blank for frames 2-3, and visible again; other digits are unaffected.
REQ-033 Cursor move: mid-blank-phase, load idx=3 -> digit 3 is visible on its next scan slot, and the scan pointer sequence is unbroken.
REQ-034 PIN_MASK_EN defined: load 16'h4321, idx=2, edit=1 -> digits 0,1 show 0111111; digit 2 shows 3 and blinks; digit 3 shows 4. Then edit=0 -> all four digits show 0111111.
REQ-035 Reset mid-scan: assert rst_n_i=0 together with load_i=1 at pointer 2 -> next cycle an_o=1111 and the shadow is cleared; the load is discarded.
